unidade_despacho_param: RTL



---
 rtl/unidade_despacho_param.sv | 138 +++++++++++++
 1 files changed

// File: rtl/unidade_despacho_param.sv
// Tomasulo issue/dispatch unit: owns the register-status table and the station busy mask,
// resolves source operands (with same-cycle CDB bypass) and issues to the lowest free station.
module unidade_despacho_param #(
  parameter int              DATA_W   = 16,
  parameter int              NUM_REGS = 8,
  parameter int              NUM_RS   = 4,
  parameter int              TAG_W    = 3,
  parameter logic [DATA_W-1:0] VAL_NONE = 16'hFFF0
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Instr_Valid,
  input  logic [15:0]                  Instr,
  output logic                         Instr_Ready,
  input  logic [NUM_REGS*DATA_W-1:0]   Reg_Data,
  input  logic                         Cdb_Valid,
  input  logic [TAG_W-1:0]             Cdb_Tag,
  input  logic [DATA_W-1:0]            Cdb_Data,
  input  logic [NUM_RS-1:0]            Rs_Release,
  output logic                         Disp_Valid,
  output logic [NUM_RS-1:0]            Disp_Rs_Sel,
  output logic [2:0]                   Disp_Op,
  output logic [DATA_W-1:0]            Vj,
  output logic [DATA_W-1:0]            Vk,
  output logic [TAG_W-1:0]             Qj,
  output logic [TAG_W-1:0]             Qk,
  output logic [NUM_REGS*TAG_W-1:0]    Qi_Status
);

  logic [TAG_W-1:0]  qi [NUM_REGS];
  logic [DATA_W-1:0] reg_arr [NUM_REGS];
  logic [NUM_RS-1:0] busy;

  logic [2:0] op_f, ri_f, rj_f, rk_f;
  logic       unused_instr_bits;

  assign op_f = Instr[15:13];
  assign ri_f = Instr[12:10];
  assign rj_f = Instr[9:7];
  assign rk_f = Instr[5:3];
  assign unused_instr_bits = ^{Instr[6], Instr[2:0]};

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      reg_arr[r]                    = Reg_Data[r*DATA_W +: DATA_W];
      Qi_Status[r*TAG_W +: TAG_W]   = qi[r];
    end
  end

  // Lowest-index free station, judged on the pre-edge busy mask only.
  logic [NUM_RS-1:0] sel_oh;
  logic [TAG_W-1:0]  sel_tag;
  logic              found;

  always_comb begin
    sel_oh  = '0;
    sel_tag = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (!busy[i] && !found) begin
        found     = 1'b1;
        sel_oh[i] = 1'b1;
        sel_tag   = TAG_W'(i + 1);
      end
    end
  end

  assign Instr_Ready = !Reset && found;

  logic accept;
  assign accept = Instr_Valid && Instr_Ready;

  logic [TAG_W-1:0]  src_qj, src_qk, res_qj, res_qk;
  logic [DATA_W-1:0] res_vj, res_vk;

  assign src_qj = qi[rj_f];
  assign src_qk = qi[rk_f];

  // A nonzero tag can only match a nonzero Cdb_Tag, so tag 0 never bypasses.
  always_comb begin
    res_vj = VAL_NONE;
    res_qj = src_qj;
    if (src_qj == '0) begin
      res_vj = reg_arr[rj_f];
      res_qj = '0;
    end else if (Cdb_Valid && src_qj == Cdb_Tag) begin
      res_vj = Cdb_Data;
      res_qj = '0;
    end
  end

  always_comb begin
    res_vk = VAL_NONE;
    res_qk = src_qk;
    if (src_qk == '0) begin
      res_vk = reg_arr[rk_f];
      res_qk = '0;
    end else if (Cdb_Valid && src_qk == Cdb_Tag) begin
      res_vk = Cdb_Data;
      res_qk = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int r = 0; r < NUM_REGS; r++) qi[r] <= '0;
      busy        <= '0;
      Disp_Valid  <= 1'b0;
      Disp_Rs_Sel <= '0;
      Disp_Op     <= '0;
      Vj          <= VAL_NONE;
      Vk          <= VAL_NONE;
      Qj          <= '0;
      Qk          <= '0;
    end else begin
      busy <= (busy & ~Rs_Release) | (accept ? sel_oh : '0);

      // Destination tagging wins over a CDB clear of the same register.
      for (int r = 0; r < NUM_REGS; r++) begin
        if (accept && ri_f == 3'(r))
          qi[r] <= sel_tag;
        else if (Cdb_Valid && Cdb_Tag != '0 && qi[r] == Cdb_Tag)
          qi[r] <= '0;
      end

      Disp_Valid  <= accept;
      Disp_Rs_Sel <= accept ? sel_oh : '0;
      if (accept) begin
        Disp_Op <= op_f;
        Vj      <= res_vj;
        Vk      <= res_vk;
        Qj      <= res_qj;
        Qk      <= res_qk;
      end
    end
  end

endmodule
